box_h_window_gen_fp16: RTL

Horizontal sliding-window generator that feeds the 1×WINDOW_WIDTH floating-point convolution wrappers, e.g. the horizontal box filters in the dfdd pipeline. It accepts a raster pixel stream and emits one zero-padded, column-centred window per input pixel. Output uses the convolution's `window_i`/`col_i`/`row_i`/`valid_i` interface. It stalls upstream for R = (WINDOW_WIDTH-1)/2 cycles at each row end to flush the right border. The block is a pure data mover: no arithmetic on pixel values.

---
 rtl/box_h_window_gen_fp16.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/box_h_window_gen_fp16.sv
// Horizontal sliding-window generator: one zero-padded, column-centred 1xWINDOW_WIDTH
// window per input pixel, with an R-cycle zero flush at each row end for the right border.
//
// state   | meaning
// S_IDLE  | waiting for a col 0 pixel; other accepted pixels are dropped
// S_RUN   | shifting in pixels of the current row
// S_FLUSH | R zero shifts emit the right-border windows; upstream is stalled
module box_h_window_gen_fp16 #(
    parameter int EXP_WIDTH    = 5,
    parameter int FRAC_WIDTH   = 10,
    parameter int WINDOW_WIDTH = 7,
    parameter int IMAGE_WIDTH  = 640,
    parameter int FP_WIDTH_REG = 1 + FRAC_WIDTH + EXP_WIDTH
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [FP_WIDTH_REG-1:0] data_i,
    input  logic [15:0]             col_i,
    input  logic [15:0]             row_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    output logic [FP_WIDTH_REG-1:0] window_o [0:0][0:WINDOW_WIDTH-1],
    output logic [15:0]             col_o,
    output logic [15:0]             row_o,
    output logic                    valid_o
);

    localparam int          R          = (WINDOW_WIDTH - 1) / 2;
    localparam logic [15:0] LAST_COL   = 16'(IMAGE_WIDTH - 1);
    localparam logic [15:0] LAST_FLUSH = 16'(R - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [FP_WIDTH_REG-1:0] sr      [WINDOW_WIDTH];
    logic [FP_WIDTH_REG-1:0] sr_nxt  [WINDOW_WIDTH];
    logic [FP_WIDTH_REG-1:0] win_nxt [WINDOW_WIDTH];
    logic [15:0]             cnt;
    logic [15:0]             cnt_nxt;
    logic [15:0]             fcnt;
    logic [15:0]             fcnt_nxt;
    logic [15:0]             row_q;
    logic [15:0]             row_nxt;
    logic                    accept;
    logic                    shift_en;
    logic                    emit;
    int                      shift_idx;
    int                      centre;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        ready_o   = (state != S_FLUSH);
        accept    = valid_i && ready_o;
        state_nxt = state;
        cnt_nxt   = cnt;
        fcnt_nxt  = fcnt;
        row_nxt   = row_q;
        shift_en  = 1'b0;
        shift_idx = 0;

        // Shifted image of sr; only committed when shift_en is set.
        for (int k = 0; k < WINDOW_WIDTH - 1; k++) begin
            sr_nxt[k] = sr[k+1];
        end
        sr_nxt[WINDOW_WIDTH-1] = (state == S_FLUSH) ? '0 : data_i;

        case (state)
            S_IDLE, S_RUN: begin
                if (accept) begin
                    if (col_i == 16'd0) begin
                        shift_en = 1'b1;
                        cnt_nxt  = 16'd0;
                        row_nxt  = row_i;
                    end else if (state == S_RUN) begin
                        shift_en = 1'b1;
                        cnt_nxt  = cnt + 16'd1;
                    end
                    if (shift_en) begin
                        shift_idx = int'(cnt_nxt);
                        if (cnt_nxt == LAST_COL) begin
                            state_nxt = S_FLUSH;
                            fcnt_nxt  = 16'd0;
                        end else begin
                            state_nxt = S_RUN;
                        end
                    end
                end
            end
            S_FLUSH: begin
                shift_en  = 1'b1;
                shift_idx = IMAGE_WIDTH + int'(fcnt);
                fcnt_nxt  = fcnt + 16'd1;
                if (fcnt == LAST_FLUSH) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        emit   = shift_en && (shift_idx >= R);
        centre = shift_idx - R;
        // Taps outside the row are zeroed; this also hides stale previous-row data.
        for (int k = 0; k < WINDOW_WIDTH; k++) begin
            if ((centre - R + k < 0) || (centre - R + k >= IMAGE_WIDTH)) begin
                win_nxt[k] = '0;
            end else begin
                win_nxt[k] = sr_nxt[k];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt     <= 16'd0;
            fcnt    <= 16'd0;
            row_q   <= 16'd0;
            valid_o <= 1'b0;
            col_o   <= 16'd0;
            row_o   <= 16'd0;
            for (int k = 0; k < WINDOW_WIDTH; k++) begin
                sr[k]          <= '0;
                window_o[0][k] <= '0;
            end
        end else begin
            cnt     <= cnt_nxt;
            fcnt    <= fcnt_nxt;
            row_q   <= row_nxt;
            valid_o <= emit;
            if (shift_en) begin
                for (int k = 0; k < WINDOW_WIDTH; k++) begin
                    sr[k] <= sr_nxt[k];
                end
            end
            if (emit) begin
                col_o <= 16'(centre);
                row_o <= row_nxt;
                for (int k = 0; k < WINDOW_WIDTH; k++) begin
                    window_o[0][k] <= win_nxt[k];
                end
            end
        end
    end

endmodule
